proc_run_monitor: RTL

- Synthesisable, parametrised run checker for the CPU cores. Sits beside a `singlecycle` (or later pipelined) instance in simulation and FPGA bring-up.
- Each clock it samples the core's `currentpc` and `MemtoRegOut`. It compares the result against up to NUM_CHECKS programmable PC checkpoints plus one end-of-program check.
- It counts passes, flags failures per checkpoint, enforces a cycle-count watchdog and reports done/timeout/all-pass.

---
 rtl/proc_run_monitor.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/proc_run_monitor.sv
// Run checker for CPU cores: compares sampled PC/result against programmable
// checkpoints and an end-of-program value, with a RUN-cycle watchdog.
module proc_run_monitor #(
    parameter int unsigned        DATA_W     = 64,
    parameter int unsigned        NUM_CHECKS = 4,
    parameter int unsigned        WDOG_W     = 16,
    parameter int unsigned        WDOG_LIMIT = 255,
    parameter logic [DATA_W-1:0]  END_PC     = 'h54
) (
    input  logic                         CLK,
    input  logic                         resetl,
    input  logic                         start,
    input  logic [DATA_W-1:0]            currentpc,
    input  logic [DATA_W-1:0]            result,
    input  logic [NUM_CHECKS*DATA_W-1:0] chk_pc,
    input  logic [NUM_CHECKS*DATA_W-1:0] chk_val,
    input  logic [NUM_CHECKS-1:0]        chk_en,
    input  logic [DATA_W-1:0]            final_val,
    input  logic                         final_en,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout,
    output logic                         all_pass,
    output logic [7:0]                   pass_count,
    output logic [NUM_CHECKS-1:0]        hit_mask,
    output logic [NUM_CHECKS:0]          fail_mask,
    output logic [WDOG_W-1:0]            cycles
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TMO} state_t;

    localparam logic [WDOG_W-1:0] LIMIT    = WDOG_W'(WDOG_LIMIT);
    localparam logic [WDOG_W-1:0] LIMIT_M1 = WDOG_W'(WDOG_LIMIT - 1);

    state_t                state_q, state_nx;
    logic [WDOG_W-1:0]     cycles_q, cycles_nx;
    logic [7:0]            pass_q, pass_nx;
    logic [NUM_CHECKS-1:0] hit_q, hit_nx;
    logic [NUM_CHECKS:0]   fail_q, fail_nx;
    logic                  done_q, done_nx;
    logic                  tmo_q, tmo_nx;
    logic                  allp_q, allp_nx;
    logic [8:0]            pass_inc;
    logic [8:0]            pass_sum;
    logic                  end_hit;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q  <= S_IDLE;
            cycles_q <= '0;
            pass_q   <= '0;
            hit_q    <= '0;
            fail_q   <= '0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            allp_q   <= 1'b0;
        end else begin
            state_q  <= state_nx;
            cycles_q <= cycles_nx;
            pass_q   <= pass_nx;
            hit_q    <= hit_nx;
            fail_q   <= fail_nx;
            done_q   <= done_nx;
            tmo_q    <= tmo_nx;
            allp_q   <= allp_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        cycles_nx = cycles_q;
        pass_nx   = pass_q;
        hit_nx    = hit_q;
        fail_nx   = fail_q;
        done_nx   = done_q;
        tmo_nx    = tmo_q;
        allp_nx   = allp_q;
        pass_inc  = '0;
        pass_sum  = '0;
        end_hit   = 1'b0;

        case (state_q)
            S_RUN: begin
                // Checkpoints are evaluated even on the edge that ends the run.
                for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
                    if (chk_en[i] && !hit_q[i] &&
                        currentpc == chk_pc[i*DATA_W +: DATA_W]) begin
                        hit_nx[i] = 1'b1;
                        if (result == chk_val[i*DATA_W +: DATA_W])
                            pass_inc = pass_inc + 9'd1;
                        else
                            fail_nx[i] = 1'b1;
                    end
                end

                end_hit = (currentpc >= END_PC);
                if (end_hit) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                    if (final_en) begin
                        if (result == final_val)
                            pass_inc = pass_inc + 9'd1;
                        else
                            fail_nx[NUM_CHECKS] = 1'b1;
                    end
                end else if (cycles_q == LIMIT_M1) begin
                    state_nx = S_TMO;
                    tmo_nx   = 1'b1;
                end

                if (cycles_q != LIMIT)
                    cycles_nx = cycles_q + 1'b1;

                pass_sum = {1'b0, pass_q} + pass_inc;
                pass_nx  = (pass_sum > 9'd255) ? 8'hFF : pass_sum[7:0];

                if (end_hit)
                    allp_nx = ((hit_nx & chk_en) == chk_en) && (fail_nx == '0);
            end
            default: begin
                if (start) begin
                    state_nx  = S_RUN;
                    cycles_nx = '0;
                    pass_nx   = '0;
                    hit_nx    = '0;
                    fail_nx   = '0;
                    done_nx   = 1'b0;
                    tmo_nx    = 1'b0;
                    allp_nx   = 1'b0;
                end
            end
        endcase
    end

    assign busy       = (state_q == S_RUN);
    assign done       = done_q;
    assign timeout    = tmo_q;
    assign all_pass   = allp_q;
    assign pass_count = pass_q;
    assign hit_mask   = hit_q;
    assign fail_mask  = fail_q;
    assign cycles     = cycles_q;

endmodule
